demux14_seq: RTL and testbench
==============================

# demux14_seq

Registered 1-to-4 demultiplexer, the receive-side counterpart of the 4:1 multiplexer in the multiplexer library. It accepts a single W-bit data stream with a valid qualifier and steers each word into one of four held output channels. The channel comes either from an explicit select or from an internal round-robin pointer that rebuilds 4-word frames. Per-channel strobes, a frame-done pulse and a sticky partial-frame error are provided for downstream logic.

## Interface
- W, 8, data width of input word and each output channel (W >= 1)

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  word on in_data is accepted this cycle
- in_data  input  W  data word
- auto_mode  input  1  1 = route by internal pointer; 0 = route by s
- s  input  2  manual channel select (used only when auto_mode = 0)
- frame_start  input  1  one-cycle pulse; resynchronises pointer to channel 0
- err_clr  input  1  clears err
- y0, y1, y2, y3  output  W each  registered channel data; holds last word written
- v  output  4  one-cycle write strobe per channel (v[k] ↔ yk)
- ptr  output  2  current round-robin pointer
- frame_done  output  1  one-cycle pulse: auto-mode word just written to channel 3
- err  output  1  sticky: frame abandoned mid-way

## Operation
- Target channel: tgt = auto_mode ? eff_ptr : s.
  - eff_ptr = frame_start ? 0 : ptr.
- In a cycle with in_valid = 1:
  - y[tgt] <= in_data.
  - v[tgt] <= 1. All other v bits <= 0.
  - Non-target y registers hold.
- In a cycle with in_valid = 0: v <= 0 and all y registers hold.
- Pointer update, in priority order:
  - auto_mode & in_valid: ptr <= eff_ptr + 1. Arithmetic is mod 4, so 3 wraps to 0.
  - frame_start, without the case above: ptr <= 0.
  - Otherwise ptr holds. Manual-mode writes never move ptr.
- frame_done <= auto_mode & in_valid & (eff_ptr == 3).
- err is set when frame_start = 1 and ptr != 0, i.e. a partial auto frame is abandoned.
  - The set condition is evaluated in either mode.
- err is cleared when err_clr = 1 and the set condition is false.
  - If set and clear coincide, set wins.
- Mode changes take effect in the same cycle; there is no pipeline flush. ptr keeps its value across a mode switch.
- Reset value of every output (ptr is the pointer state itself):
  - y0..y3 = 0.
  - v = 0.
  - ptr = 0.
  - frame_done = 0.
  - err = 0.

## Timing
- Latency: a word accepted at edge N appears on y[tgt] immediately after edge N. v[tgt] is high for exactly the following cycle.
- frame_done is aligned with v[3] of the frame's 4th word.
- Throughput: one word per cycle, no backpressure. A word is accepted on every in_valid.
- Simultaneous events:
  - frame_start + in_valid in auto mode: the word goes to channel 0 and ptr becomes 1.
  - If ptr was nonzero in that cycle, err is also set.
- Back-to-back auto words: channel order 0,1,2,3,0,... with no gap cycle. frame_done fires every 4th word.
- Asynchronous reset assertion mid-frame clears all state immediately, independent of clk.
- After reset deasserts, the first auto word goes to channel 0.
- Deassertion of rst_n is assumed synchronised externally.

## Test plan
- Reset with garbage on inputs, then release:
  - y0..y3 = 0, v = 0, ptr = 0, frame_done = 0, err = 0.
  - Asserting rst_n = 0 mid-frame with ptr = 2 returns ptr to 0 without a clock edge.
- Manual mode, s = 2, in_data = 0xA5 for one cycle:
  - y2 = 0xA5 and v = 4'b0100 for one cycle.
  - y0, y1, y3 unchanged; ptr unchanged.
- Auto mode, 8 consecutive valid words 0x10..0x17:
  - Channel order 0,1,2,3,0,1,2,3.
  - Final y0..y3 = 0x14, 0x15, 0x16, 0x17.
  - frame_done high exactly after the 4th and 8th words.
- Auto mode, 2 words, then frame_start coincident with word 0x33:
  - y0 = 0x33, ptr = 1, err = 1.
  - err_clr then returns err to 0; err_clr and frame_start with ptr = 1 in the same cycle leaves err = 1.
- Auto mode, 2 words, then switch to manual with s = 3 and write 0x77:
  - y3 = 0x77 and ptr stays 2.
  - Switching back to auto, the next word lands in channel 2.
- Gaps: auto mode with in_valid toggling 1,0,1,0:
  - v and ptr advance only on valid cycles.
  - No strobe appears in idle cycles.

Source files
------------

// File: rtl/demux14_seq.sv
// Registered 1-to-4 demultiplexer with a round-robin frame pointer.
// Each word is steered to one held channel register, either by s or by the pointer.
module demux14_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         auto_mode,
  input  logic [1:0]   s,
  input  logic         frame_start,
  input  logic         err_clr,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [3:0]   v,
  output logic [1:0]   ptr,
  output logic         frame_done,
  output logic         err
);

  logic [1:0] eff_ptr;
  logic [1:0] tgt;
  logic       err_set;

  // frame_start forces the current word to channel 0 when it coincides with data
  always_comb begin
    eff_ptr = frame_start ? 2'd0 : ptr;
    tgt     = auto_mode ? eff_ptr : s;
    err_set = frame_start && (ptr != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0 <= '0;
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
    end else if (in_valid) begin
      case (tgt)
        2'd0:    y0 <= in_data;
        2'd1:    y1 <= in_data;
        2'd2:    y2 <= in_data;
        default: y3 <= in_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v          <= '0;
      ptr        <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      v <= '0;
      if (in_valid) v[tgt] <= 1'b1;

      // manual-mode writes leave the pointer alone
      if (auto_mode && in_valid) ptr <= eff_ptr + 2'd1;
      else if (frame_start)      ptr <= 2'd0;

      frame_done <= auto_mode && in_valid && (eff_ptr == 2'd3);

      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux14_seq.sv
// Directed-vector bench for demux14_seq; each task drives one scenario and checks inline.
module tb_demux14_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         auto_mode = 1'b0;
  logic [1:0]   s = 2'd0;
  logic         frame_start = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   v;
  logic [1:0]   ptr;
  logic         frame_done;
  logic         err;

  int n_vec = 0;
  int n_err = 0;

  demux14_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .auto_mode(auto_mode), .s(s), .frame_start(frame_start), .err_clr(err_clr),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .v(v), .ptr(ptr),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    frame_start = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic word(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 8'hFF; auto_mode = 1'b1; s = 2'd3;
    frame_start = 1'b1; err_clr = 1'b0;
    #3 rst_n = 1'b0;
    step();
    step();
    n_vec++;
    if ({y0, y1, y2, y3} !== 32'h0) begin
      n_err++; $display("FAIL reset_y got %h want 00000000", {y0, y1, y2, y3});
    end
    n_vec++;
    if ({v, ptr, frame_done, err} !== 8'h00) begin
      n_err++; $display("FAIL reset_ctl got v=%b ptr=%0d fd=%b err=%b want 0", v, ptr, frame_done, err);
    end
    rst_n = 1'b1;
    idle();
    step();
    n_vec++;
    if ({y0, y1, y2, y3, v, ptr, frame_done, err} !== 40'h0) begin
      n_err++; $display("FAIL reset_release got y=%h v=%b ptr=%0d err=%b want 0", {y0, y1, y2, y3}, v, ptr, err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    auto_mode = 1'b1;
    word(8'h51);
    word(8'h52);
    idle();
    n_vec++;
    if (ptr !== 2'd2) begin
      n_err++; $display("FAIL async_pre_ptr got %0d want 2", ptr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (ptr !== 2'd0 || y0 !== 8'h00 || y1 !== 8'h00) begin
      n_err++; $display("FAIL async_reset got ptr=%0d y0=%h y1=%h want 0", ptr, y0, y1);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    do_reset();
    auto_mode = 1'b0; s = 2'd2;
    word(8'hA5);
    idle();
    n_vec++;
    if (y2 !== 8'hA5 || v !== 4'b0100) begin
      n_err++; $display("FAIL manual_write got y2=%h v=%b want a5 0100", y2, v);
    end
    n_vec++;
    if (y0 !== 8'h00 || y1 !== 8'h00 || y3 !== 8'h00 || ptr !== 2'd0 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL manual_others got y0=%h y1=%h y3=%h ptr=%0d fd=%b want 0", y0, y1, y3, ptr, frame_done);
    end
    step();
    n_vec++;
    if (v !== 4'b0000 || y2 !== 8'hA5) begin
      n_err++; $display("FAIL manual_hold got v=%b y2=%h want 0000 a5", v, y2);
    end
  endtask

  task automatic test_auto8();
    logic [3:0] exp_v;
    do_reset();
    auto_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      word(8'h10 + 8'(i));
      exp_v = 4'b0001 << (i % 4);
      n_vec++;
      if (v !== exp_v || frame_done !== ((i % 4) == 3) || ptr !== 2'((i + 1) % 4)) begin
        n_err++; $display("FAIL auto8_word%0d got v=%b fd=%b ptr=%0d want v=%b fd=%b ptr=%0d",
                          i, v, frame_done, ptr, exp_v, ((i % 4) == 3), (i + 1) % 4);
      end
    end
    idle();
    n_vec++;
    if ({y0, y1, y2, y3} !== 32'h14151617) begin
      n_err++; $display("FAIL auto8_final got %h want 14151617", {y0, y1, y2, y3});
    end
    step();
    n_vec++;
    if (frame_done !== 1'b0 || v !== 4'b0000) begin
      n_err++; $display("FAIL auto8_idle got fd=%b v=%b want 0 0000", frame_done, v);
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    auto_mode = 1'b1;
    word(8'h20);
    word(8'h21);
    frame_start = 1'b1;
    word(8'h33);
    idle();
    n_vec++;
    if (y0 !== 8'h33 || v !== 4'b0001 || ptr !== 2'd1 || err !== 1'b1) begin
      n_err++; $display("FAIL fs_word got y0=%h v=%b ptr=%0d err=%b want 33 0001 1 1", y0, v, ptr, err);
    end
    step();
    n_vec++;
    if (err !== 1'b1) begin
      n_err++; $display("FAIL fs_sticky got err=%b want 1", err);
    end
    err_clr = 1'b1;
    step();
    idle();
    n_vec++;
    if (err !== 1'b0 || ptr !== 2'd1) begin
      n_err++; $display("FAIL fs_clear got err=%b ptr=%0d want 0 1", err, ptr);
    end
    err_clr = 1'b1; frame_start = 1'b1;
    step();
    idle();
    n_vec++;
    if (err !== 1'b1 || ptr !== 2'd0) begin
      n_err++; $display("FAIL fs_set_wins got err=%b ptr=%0d want 1 0", err, ptr);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    auto_mode = 1'b1;
    word(8'h60);
    word(8'h61);
    auto_mode = 1'b0; s = 2'd3;
    word(8'h77);
    n_vec++;
    if (y3 !== 8'h77 || v !== 4'b1000 || ptr !== 2'd2 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL switch_manual got y3=%h v=%b ptr=%0d fd=%b want 77 1000 2 0", y3, v, ptr, frame_done);
    end
    auto_mode = 1'b1;
    word(8'h88);
    idle();
    n_vec++;
    if (y2 !== 8'h88 || v !== 4'b0100 || ptr !== 2'd3) begin
      n_err++; $display("FAIL switch_auto got y2=%h v=%b ptr=%0d want 88 0100 3", y2, v, ptr);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] exp_v [4];
    logic [1:0] exp_p [4];
    exp_v = '{4'b0001, 4'b0000, 4'b0010, 4'b0000};
    exp_p = '{2'd1, 2'd1, 2'd2, 2'd2};
    do_reset();
    auto_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = ((i % 2) == 0);
      in_data  = 8'h40 + 8'(i);
      step();
      n_vec++;
      if (v !== exp_v[i] || ptr !== exp_p[i]) begin
        n_err++; $display("FAIL gaps_cycle%0d got v=%b ptr=%0d want v=%b ptr=%0d", i, v, ptr, exp_v[i], exp_p[i]);
      end
    end
    idle();
    n_vec++;
    if (y0 !== 8'h40 || y1 !== 8'h42) begin
      n_err++; $display("FAIL gaps_data got y0=%h y1=%h want 40 42", y0, y1);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_manual();
    test_auto8();
    test_frame_start();
    test_mode_switch();
    test_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
